i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
- Round-robin arbiter that shares the single-transaction I2C write master (start/addr/data/ready handshake) between NUM_REQ requesters.
- Latches the winner's 7-bit address and 8-bit data, launches the master, tracks acceptance and completion, and reports done or error per requester.
- Adds bus-free gap time between transactions and watchdogs a master that never accepts or never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACC_LIMIT, 4, cycles m_start may stay high without m_ready falling before an accept timeout.
- TXN_LIMIT, 64, cycles after acceptance that m_ready may stay low before a transaction timeout.
- GAP_CYCLES, 2, idle cycles forced after every transaction, min 1.
- IDXW, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  level request per requester; hold req, req_addr and req_data stable until req_ack.
- req_addr  input  7*NUM_REQ  flattened; slice i = bits [7i+6:7i].
- req_data  input  8*NUM_REQ  flattened; slice i = bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-cycle pulse: request i granted and its operands latched.
- req_done  output  NUM_REQ  one-cycle pulse: transaction i finished (successfully or not).
- req_err  output  NUM_REQ  one-cycle pulse coincident with req_done: transaction i timed out.
- m_start  output  1  start strobe to the I2C master.
- m_addr  output  7  latched address to the master.
- m_data  output  8  latched data to the master.
- m_ready  input  1  master idle indication (high = idle).
- busy  output  1  high in every state except IDLE.
- grant_id  output  IDXW  index of the current or most recent grant.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; round-robin pointer to 0.
  - All outputs 0: m_addr, m_data, grant_id, req_ack, req_done, req_err, m_start, busy.
  - Counters cleared.
  - Mid-transaction reset drops m_start immediately; no done is reported for the aborted request.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - Arbitrate only when m_ready=1 and req≠0.
  - Winner = first set bit of req, scanning upward from the pointer and wrapping at NUM_REQ-1 to 0.
  - Same cycle: latch the winner's slice into m_addr/m_data, set grant_id, pulse req_ack[winner], set m_start=1, go to LAUNCH.
  - m_ready=0 in IDLE: no grant.
- LAUNCH:
  - Hold m_start=1 until m_ready is sampled 0; then m_start←0, clear the counter, go to BUSY.
  - If the counter reaches ACC_LIMIT with m_ready still 1: m_start←0, pulse req_done and req_err for grant_id, go to GAP.
- BUSY:
  - When m_ready is sampled 1: pulse req_done[grant_id] (req_err=0), go to GAP.
  - If the counter reaches TXN_LIMIT with m_ready=0: pulse req_done and req_err, go to GAP.
- GAP:
  - Stay GAP_CYCLES cycles, then go to IDLE.
  - On GAP entry the pointer ← grant_id+1, modulo NUM_REQ, so the just-served requester has lowest priority next time.
- Requests:
  - Sampled only in IDLE, so no two grants are closer than 3+GAP_CYCLES cycles.
  - A req still high after its ack is treated as a new request at the next arbitration.
  - A requester that deasserts req before ack is never granted; no partial state is kept.
  - req changing during LAUNCH, BUSY or GAP has no effect; m_addr/m_data stay constant from ack until the next grant.
- Timing:
  - Best-case latency from req high (FSM in IDLE, m_ready=1) to m_start high is 1 cycle.
  - req_ack and m_start rise in the same cycle.
- At most one bit of req_ack, req_done or req_err is set in any cycle.
- Pointer arithmetic wraps with no out-of-range index for non-power-of-2 NUM_REQ (for example 3).

Test Plan:
- Single request: req=0001, addr=0x50, data=0xA5, model master drops ready 1 cycle after start and holds it low 20 cycles -> req_ack[0] pulse; m_start high exactly until ready falls; m_addr=0x50, m_data=0xA5; req_done[0] pulse 1 cycle after ready returns; req_err=0.
- Simultaneous requests: req=1010 from reset -> grant 1 first; after its GAP, grant 3; pointer then 0.
- Fairness: all four requests held high continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Accept timeout: m_ready stuck at 1, req=0100 -> m_start high ACC_LIMIT cycles, then req_done[2] and req_err[2] pulse together; FSM returns to IDLE after GAP_CYCLES.
- Transaction timeout: master accepts but holds ready low 100 cycles -> req_done[0] and req_err[0] pulse after TXN_LIMIT=64 cycles in BUSY; later request 1 is served normally.
- Reset mid-BUSY: assert reset low asynchronously between clock edges -> m_start, busy and all pulses go 0 immediately; after release, a pending req=0001 is granted with the pointer at 0.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter
// Brief    : Round-robin arbiter sharing one I2C write master among NUM_REQ
//            requesters, with accept/transaction watchdogs and a bus-free gap.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ACC_LIMIT  = 4,
    parameter int TXN_LIMIT  = 64,
    parameter int GAP_CYCLES = 2,
    parameter int IDXW       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [IDXW-1:0]        grant_id
);

    localparam int c_MAX_LIM = (TXN_LIMIT > ACC_LIMIT)
                             ? ((TXN_LIMIT > GAP_CYCLES) ? TXN_LIMIT : GAP_CYCLES)
                             : ((ACC_LIMIT > GAP_CYCLES) ? ACC_LIMIT : GAP_CYCLES);
    localparam int                c_CNTW = $clog2(c_MAX_LIM + 1);
    localparam logic [IDXW:0]     c_NUM  = (IDXW+1)'(NUM_REQ);
    localparam logic [IDXW-1:0]   c_LAST = IDXW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNTW-1:0]    r_cnt, w_cnt_nxt;
    logic [IDXW-1:0]      r_ptr, w_ptr_nxt;
    logic [IDXW-1:0]      r_grant, w_grant_nxt;
    logic [6:0]           r_addr, w_addr_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_start, w_start_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_err, w_err_nxt;

    logic                 w_found;
    logic [IDXW-1:0]      w_win;
    logic [IDXW:0]        w_scan;
    logic [IDXW-1:0]      w_ptr_adv;

    // Scan upward from the pointer; the extra index bit lets the sum wrap
    // cleanly for non-power-of-two requester counts.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDXW+1)'(k);
            if (w_scan >= c_NUM) begin
                w_scan = w_scan - c_NUM;
            end
            if (!w_found && req[w_scan[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[IDXW-1:0];
            end
        end
    end

    assign w_ptr_adv = (r_grant == c_LAST) ? '0 : r_grant + IDXW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_start_nxt = r_start;
        w_ack_nxt   = '0;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (m_ready && w_found) begin
                    w_addr_nxt  = req_addr[7*int'(w_win) +: 7];
                    w_data_nxt  = req_data[8*int'(w_win) +: 8];
                    w_grant_nxt = w_win;
                    w_ack_nxt   = c_ONE << w_win;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!m_ready) begin
                    w_start_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end else if (r_cnt == c_CNTW'(ACC_LIMIT - 1)) begin
                    w_start_nxt = 1'b0;
                    w_done_nxt  = c_ONE << r_grant;
                    w_err_nxt   = c_ONE << r_grant;
                    w_ptr_nxt   = w_ptr_adv;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNTW'(1);
                end
            end
            S_BUSY: begin
                if (m_ready) begin
                    w_done_nxt  = c_ONE << r_grant;
                    w_ptr_nxt   = w_ptr_adv;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == c_CNTW'(TXN_LIMIT - 1)) begin
                    w_done_nxt  = c_ONE << r_grant;
                    w_err_nxt   = c_ONE << r_grant;
                    w_ptr_nxt   = w_ptr_adv;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNTW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == c_CNTW'(GAP_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNTW'(1);
                end
            end
            default: begin
                w_start_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign req_ack  = r_ack;
    assign req_done = r_done;
    assign req_err  = r_err;
    assign m_start  = r_start;
    assign m_addr   = r_addr;
    assign m_data   = r_data;
    assign busy     = r_busy;
    assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Brief    : Directed self-checking bench for i2c_req_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic        m_start;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic [1:0]  grant_id;

    logic [6:0]  exp_addr [4];
    logic [7:0]  exp_data [4];
    int          n_checks;
    int          n_errors;

    i2c_req_arbiter #(
        .NUM_REQ    (4),
        .ACC_LIMIT  (4),
        .TXN_LIMIT  (64),
        .GAP_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ack  (req_ack),
        .req_done (req_done),
        .req_err  (req_err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns the number of negedges waited for an ack, 0 on timeout.
    task automatic wait_ack(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (req_ack != 4'b0) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) check_value("ack_wait", 32'd0, 32'd1);
    endtask

    // Master model: accept right after the start strobe, stay busy for
    // low_cycles clocks, then go idle and expect a clean done pulse.
    task automatic run_txn(input int id, input int low_cycles, input bit drop, output int lat);
        bit got;
        wait_ack(lat);
        if (lat == 0) return;
        check_value("ack_vec",  32'(req_ack), 32'd1 << id);
        check_value("grant_id", 32'(grant_id), 32'(id));
        check_value("start_on", 32'(m_start), 32'd1);
        check_value("m_addr",   32'(m_addr), 32'(exp_addr[id]));
        check_value("m_data",   32'(m_data), 32'(exp_data[id]));
        if (drop) req[id] = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check_value("start_off", 32'(m_start), 32'd0);
        check_value("ack_pulse", 32'(req_ack), 32'd0);
        repeat (low_cycles - 1) @(negedge clk);
        m_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (req_done != 4'b0) got = 1'b1;
        end
        if (!got) begin
            check_value("done_wait", 32'd0, 32'd1);
            return;
        end
        check_value("done_vec",  32'(req_done), 32'd1 << id);
        check_value("err_clear", 32'(req_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int lat;
        int n_hi;
        int k;
        int acks;
        bit got;

        n_checks = 0;
        n_errors = 0;
        exp_addr = '{7'h50, 7'h11, 7'h2B, 7'h3C};
        exp_data = '{8'hA5, 8'h22, 8'h33, 8'h44};
        req_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        req_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
        req      = 4'b0;
        m_ready  = 1'b1;
        reset    = 1'b1;
        #1 reset = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_value("rst_busy",  32'(busy), 32'd0);
        check_value("rst_start", 32'(m_start), 32'd0);
        check_value("rst_ack",   32'(req_ack), 32'd0);
        check_value("rst_done",  32'(req_done | req_err), 32'd0);
        check_value("rst_gid",   32'(grant_id), 32'd0);
        check_value("rst_addr",  32'({m_addr, m_data}), 32'd0);
        reset = 1'b1;

        // Single request, 1-cycle latency, 20-cycle busy master
        @(negedge clk);
        req = 4'b0001;
        run_txn(0, 20, 1'b1, lat);
        check_value("lat_single", 32'(lat), 32'd1);
        @(negedge clk);
        check_value("done_pulse", 32'(req_done), 32'd0);
        check_value("gap_busy",   32'(busy), 32'd1);
        @(negedge clk);
        check_value("gap_end",    32'(busy), 32'd0);
        check_value("addr_hold",  32'(m_addr), 32'h50);

        // Simultaneous requests from reset, then pointer wraps to 0
        do_reset();
        req = 4'b1010;
        run_txn(1, 3, 1'b1, lat);
        run_txn(3, 3, 1'b1, lat);
        req = 4'b1001;
        run_txn(0, 3, 1'b1, lat);
        req = 4'b0;

        // Fairness with all requests held
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 8; t++) run_txn(t % 4, 2, 1'b0, lat);
        req = 4'b0;

        // Accept timeout: master never leaves idle
        req = 4'b0100;
        wait_ack(lat);
        check_value("acc_ack", 32'(req_ack), 32'b0100);
        req = 4'b0;
        n_hi = 0;
        for (int i = 0; i < 20 && m_start; i++) begin
            n_hi++;
            @(negedge clk);
        end
        check_value("acc_start_len", 32'(n_hi), 32'd4);
        check_value("acc_done", 32'(req_done), 32'b0100);
        check_value("acc_err",  32'(req_err), 32'b0100);
        @(negedge clk);
        check_value("acc_gap", 32'(busy), 32'd1);
        @(negedge clk);
        check_value("acc_idle", 32'(busy), 32'd0);

        // Transaction timeout, then no grant while master is not ready
        req = 4'b0001;
        wait_ack(lat);
        check_value("txn_ack", 32'(req_ack), 32'b0001);
        req = 4'b0;
        m_ready = 1'b0;
        k = 0;
        got = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge clk);
            k = i;
            if (req_done != 4'b0) got = 1'b1;
        end
        check_value("txn_to_time", 32'(k), 32'd65);
        check_value("txn_done", 32'(req_done), 32'b0001);
        check_value("txn_err",  32'(req_err), 32'b0001);
        req = 4'b0010;
        acks = 0;
        for (int i = k + 1; i <= 100; i++) begin
            @(negedge clk);
            if (req_ack != 4'b0) acks++;
        end
        check_value("no_grant_not_ready", 32'(acks), 32'd0);
        m_ready = 1'b1;
        run_txn(1, 5, 1'b1, lat);

        // Asynchronous reset in the middle of BUSY
        req = 4'b1000;
        wait_ack(lat);
        check_value("rb_ack", 32'(req_ack), 32'b1000);
        req = 4'b1001;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_value("rb_busy",  32'(busy), 32'd0);
        check_value("rb_start", 32'(m_start), 32'd0);
        check_value("rb_gid",   32'(grant_id), 32'd0);
        check_value("rb_pulse", 32'({req_ack, req_done, req_err}), 32'd0);
        check_value("rb_addr",  32'({m_addr, m_data}), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        check_value("rb_no_done", 32'(req_done), 32'd0);
        reset = 1'b1;
        run_txn(0, 2, 1'b1, lat);
        req = 4'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
